// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [0:0] {
    KP_IDLE = 1'b0,
    KP_HELD = 1'b1
  } kp_state_t;

  localparam int KP_VALID_BIT = 31;
  localparam int KP_OVF_BIT   = 30;
  localparam int KP_ROWS      = 4;
  localparam int KP_COLS      = 4;
  localparam int KP_CODE_W    = 4;
  localparam int KP_KEYS      = KP_ROWS * KP_COLS;

  function automatic logic kp_single(input logic [KP_KEYS-1:0] snap);
    return (snap != 16'd0) && ((snap & (snap - 16'd1)) == 16'd0);
  endfunction

  // Snapshot bit index is row*4+col, so the index of the set bit is the key code.
  function automatic logic [KP_CODE_W-1:0] kp_encode(input logic [KP_KEYS-1:0] snap);
    logic [KP_CODE_W-1:0] code;
    code = 4'd0;
    for (int i = KP_KEYS - 1; i >= 0; i--) begin
      if (snap[i]) code = KP_CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/kp_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module kp_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             pop_s;
  logic             push_s;

  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s  = pop && !empty;
  assign push_s = push && (!full || pop_s);
  assign dout   = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row scan, frame-level debounce, single-key press detection and a code FIFO
// read through a memory-mapped key register.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_o,
  input  logic [3:0]  col_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic        irq_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_CNT);

  logic [3:0]           col_meta_r;
  logic [3:0]           col_sync_r;
  logic [DW-1:0]        div_r;
  logic [1:0]           row_r;
  logic [11:0]          snap_r;
  logic [KP_KEYS-1:0]   prev_r;
  logic [KP_KEYS-1:0]   frame_snap_s;
  logic [MW-1:0]        match_r;
  logic                 frame_done_r;
  logic                 sample_s;
  logic                 frame_end_s;
  logic                 stable_s;
  kp_state_t            state_r;
  kp_state_t            state_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 drop_s;
  logic                 ovf_r;
  logic                 valid_s;
  logic                 fifo_full_s;
  logic [KP_CODE_W-1:0] fifo_dout_s;

  // Row 3 is never stored: its sample completes the frame directly.
  assign sample_s     = (div_r == DIV_LAST);
  assign frame_end_s  = sample_s && (row_r == 2'd3);
  assign frame_snap_s = {~col_sync_r, snap_r};
  assign stable_s     = (match_r >= MATCH_MAX);
  assign row_o        = ~(4'b0001 << row_r);

  // Column synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= col_i;
      col_sync_r <= col_meta_r;
    end
  end

  // Row divider, row index and per-row column sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r  <= '0;
      row_r  <= 2'd0;
      snap_r <= 12'd0;
    end else if (sample_s) begin
      div_r <= '0;
      row_r <= row_r + 2'd1;
      case (row_r)
        2'd0:    snap_r[3:0]  <= ~col_sync_r;
        2'd1:    snap_r[7:4]  <= ~col_sync_r;
        2'd2:    snap_r[11:8] <= ~col_sync_r;
        default: snap_r       <= snap_r;
      endcase
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // Frame-to-frame debounce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r       <= '0;
      match_r      <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
      if (frame_end_s) begin
        prev_r <= frame_snap_s;
        if (frame_snap_s != prev_r) begin
          match_r <= MW'(1);
        end else if (match_r != MATCH_MAX) begin
          match_r <= match_r + MW'(1);
        end
      end
    end
  end

  // Press FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= KP_IDLE;
    else      state_r <= state_s;
  end

  // Press FSM: acts once per completed frame, on a stable snapshot only
  always_comb begin
    state_s = state_r;
    push_s  = 1'b0;
    if (frame_done_r && stable_s) begin
      case (state_r)
        KP_IDLE: begin
          if (prev_r == 16'd0) begin
            state_s = KP_IDLE;
          end else begin
            state_s = KP_HELD;
            push_s  = kp_single(prev_r);
          end
        end
        KP_HELD: begin
          if (prev_r == 16'd0) state_s = KP_IDLE;
          else                 state_s = KP_HELD;
        end
        default: state_s = KP_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  kp_fifo #(
    .WIDTH (KP_CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (rd_i),
    .din   (kp_encode(prev_r)),
    .dout  (fifo_dout_s),
    .empty (),
    .full  (fifo_full_s)
  );

  assign valid_s = !u_fifo.empty;
  assign pop_s   = rd_i && valid_s;
  assign drop_s  = push_s && fifo_full_s && !pop_s;

  // Sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ovf_r <= 1'b0;
    else if (drop_s) ovf_r <= 1'b1;
    else if (pop_s)  ovf_r <= 1'b0;
    else             ovf_r <= ovf_r;
  end

  // Key register, show-ahead from the FIFO head
  always_comb begin
    data_o               = 32'd0;
    data_o[KP_VALID_BIT] = valid_s;
    data_o[KP_OVF_BIT]   = ovf_r;
    if (valid_s) data_o[KP_CODE_W-1:0] = fifo_dout_s;
    else         data_o[KP_CODE_W-1:0] = 4'd0;
  end

  assign irq_o = valid_s;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad model drives the columns and a scoreboard queue
// holds the codes expected from the key register.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_o;
  logic [3:0]  col_i;
  logic        rd_i;
  logic [31:0] data_o;
  logic        irq_o;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] sb[$];

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(2), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .row_o  (row_o),
    .col_i  (col_i),
    .rd_i   (rd_i),
    .data_o (data_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_o[r]) col_i[c] = 1'b0;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first cycle of a frame (row 0, divider 0).
  task automatic align_frame();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (row_o !== 4'b0111 && k < 100);
    while (row_o !== 4'b1110 && k < 100) begin @(negedge clk); k++; end
    n_cmp++;
    if (k >= 100) begin
      n_err++;
      $display("FAIL align_frame: row_o=%b never reached frame start (expected 1110)", row_o);
    end
  endtask

  task automatic pulse_rd();
    rd_i = 1'b1;
    @(negedge clk);
    rd_i = 1'b0;
  endtask

  task automatic press_key(input int k);
    align_frame();
    keys = 16'(1) << k;
    cycles(64);
    keys = 16'd0;
    cycles(64);
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_row;
    rst = 1'b0; keys = 16'd0; rd_i = 1'b0;
    cycles(3);
    n_cmp++;
    if (row_o !== 4'b1110 || data_o !== 32'd0 || irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: row_o=%b data_o=%h irq_o=%b expected 1110/00000000/0", row_o, data_o, irq_o);
    end
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      one = 4'b0001 << ((k / 4) % 4);
      exp_row = ~one;
      n_cmp++;
      if (row_o !== exp_row) begin
        n_err++;
        $display("FAIL row_step[%0d]: row_o=%b expected %b", k, row_o, exp_row);
      end
    end
  endtask

  task automatic test_single_press();
    logic [3:0] exp;
    align_frame();
    keys = 16'h0200;
    cycles(32);
    n_cmp++;
    if (data_o[31] !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency_early: valid=%b expected 0", data_o[31]);
    end
    cycles(1);
    sb.push_back(4'd9);
    n_cmp++;
    if (data_o !== 32'h8000_0009 || irq_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_push: data_o=%h irq_o=%b expected 80000009/1", data_o, irq_o);
    end
    cycles(15);
    keys = 16'd0;
    cycles(64);
    exp = sb.pop_front();
    n_cmp++;
    if (data_o !== {1'b1, 1'b0, 26'd0, exp}) begin
      n_err++;
      $display("FAIL single_head: data_o=%h expected code %h valid", data_o, exp);
    end
    pulse_rd();
    n_cmp++;
    if (data_o !== 32'd0 || irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_after_pop: data_o=%h irq_o=%b expected 00000000/0", data_o, irq_o);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp;
    align_frame();
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'd0;
      cycles(16);
    end
    keys = 16'd0;
    cycles(48);
    n_cmp++;
    if (data_o !== 32'd0) begin
      n_err++;
      $display("FAIL bounce_no_push: data_o=%h expected 00000000", data_o);
    end
    align_frame();
    keys = 16'h0200;
    cycles(33);
    sb.push_back(4'd9);
    n_cmp++;
    if (data_o !== 32'h8000_0009) begin
      n_err++;
      $display("FAIL bounce_steady_push: data_o=%h expected 80000009", data_o);
    end
    cycles(31);
    keys = 16'd0;
    cycles(64);
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      n_cmp++;
      if (data_o !== {1'b1, 1'b0, 26'd0, exp}) begin
        n_err++;
        $display("FAIL bounce_drain: data_o=%h expected code %h valid", data_o, exp);
      end
      pulse_rd();
    end
  endtask

  task automatic test_hold_multikey();
    logic [3:0] exp;
    align_frame();
    keys = 16'h0001;
    cycles(160);
    sb.push_back(4'd0);
    n_cmp++;
    if (data_o !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL hold_single_push: data_o=%h expected 80000000", data_o);
    end
    keys = 16'h0021;
    cycles(64);
    keys = 16'd0;
    cycles(64);
    press_key(5);
    sb.push_back(4'd5);
    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      exp = sb.pop_front();
      n_cmp++;
      if (data_o !== {1'b1, 1'b0, 26'd0, exp}) begin
        n_err++;
        $display("FAIL hold_drain: data_o=%h expected code %h valid", data_o, exp);
      end
      pulse_rd();
    end
    n_cmp++;
    if (data_o !== 32'd0) begin
      n_err++;
      $display("FAIL hold_empty: data_o=%h expected 00000000", data_o);
    end
  endtask

  task automatic test_overflow();
    int list[5] = '{1, 2, 3, 4, 6};
    logic [3:0] exp;
    for (int i = 0; i < 5; i++) begin
      press_key(list[i]);
      if (i < 4) sb.push_back(4'(list[i]));
    end
    n_cmp++;
    if (data_o !== 32'hC000_0001) begin
      n_err++;
      $display("FAIL ovf_full: data_o=%h expected c0000001", data_o);
    end
    exp = sb.pop_front();
    n_cmp++;
    if (data_o[3:0] !== exp) begin
      n_err++;
      $display("FAIL ovf_head: code=%h expected %h", data_o[3:0], exp);
    end
    pulse_rd();
    n_cmp++;
    if (data_o !== 32'h8000_0002) begin
      n_err++;
      $display("FAIL ovf_clear: data_o=%h expected 80000002", data_o);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      n_cmp++;
      if (data_o !== {1'b1, 1'b0, 26'd0, exp}) begin
        n_err++;
        $display("FAIL ovf_drain: data_o=%h expected code %h valid", data_o, exp);
      end
      pulse_rd();
    end
  endtask

  task automatic test_empty_read();
    pulse_rd();
    cycles(1);
    n_cmp++;
    if (data_o !== 32'd0 || irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL empty_read: data_o=%h irq_o=%b expected 00000000/0", data_o, irq_o);
    end
  endtask

  task automatic test_push_pop_full();
    logic [3:0] exp;
    for (int k = 1; k <= 4; k++) begin
      press_key(k);
      sb.push_back(4'(k));
    end
    align_frame();
    keys = 16'h0080;
    cycles(32);
    sb.push_back(4'd7);
    exp = sb.pop_front();
    n_cmp++;
    if (data_o !== {1'b1, 1'b0, 26'd0, exp}) begin
      n_err++;
      $display("FAIL pp_full_head: data_o=%h expected code %h valid", data_o, exp);
    end
    pulse_rd();
    n_cmp++;
    if (data_o !== 32'h8000_0002) begin
      n_err++;
      $display("FAIL pp_full_no_ovf: data_o=%h expected 80000002", data_o);
    end
    cycles(30);
    keys = 16'd0;
    cycles(64);
    for (int i = 0; i < 6 && sb.size() > 0; i++) begin
      exp = sb.pop_front();
      n_cmp++;
      if (data_o !== {1'b1, 1'b0, 26'd0, exp}) begin
        n_err++;
        $display("FAIL pp_drain: data_o=%h expected code %h valid", data_o, exp);
      end
      pulse_rd();
    end
    n_cmp++;
    if (data_o !== 32'd0) begin
      n_err++;
      $display("FAIL pp_empty: data_o=%h expected 00000000", data_o);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp;
    align_frame();
    keys = 16'h0008;
    cycles(34);
    n_cmp++;
    if (data_o !== 32'h8000_0003) begin
      n_err++;
      $display("FAIL ar_pre: data_o=%h expected 80000003", data_o);
    end
    cycles(5);
    #2 rst = 1'b0;
    #1;
    sb.delete();
    n_cmp++;
    if (row_o !== 4'b1110 || data_o !== 32'd0 || irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL ar_immediate: row_o=%b data_o=%h irq_o=%b expected 1110/00000000/0", row_o, data_o, irq_o);
    end
    cycles(3);
    rst = 1'b1;
    cycles(64);
    sb.push_back(4'd3);
    keys = 16'd0;
    cycles(64);
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      n_cmp++;
      if (data_o !== {1'b1, 1'b0, 26'd0, exp}) begin
        n_err++;
        $display("FAIL ar_held_key: data_o=%h expected code %h valid", data_o, exp);
      end
      pulse_rd();
    end
    n_cmp++;
    if (data_o !== 32'd0) begin
      n_err++;
      $display("FAIL ar_empty: data_o=%h expected 00000000", data_o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_hold_multikey();
    test_overflow();
    test_empty_read();
    test_push_pop_full();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
